// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared constants and address/counter helpers for the CPU memory
//             responder and its word array.
//  Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int          WORD_W              = 32;
    localparam int          LANES               = 4;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 16384;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_0000;

    // The lower-bound test must use the raw address because the offset wraps
    // when addr < base.
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_array
//  Brief    : Byte-lane word storage with two registered read ports and one
//             byte-masked write port; reads return pre-write contents.
//  Revision : 1.0
// ============================================================================
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH_WORDS,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_a_en,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [WORD_W-1:0] o_a_rdata,
    input  logic              i_b_en,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [WORD_W-1:0] o_b_rdata,
    input  logic [LANES-1:0]  i_w_be,
    input  logic [ADDR_W-1:0] i_w_addr,
    input  logic [WORD_W-1:0] i_w_data
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_a_q;
        logic [7:0] r_b_q;

        // Read and write share one block so non-blocking semantics give
        // read-first behaviour on a same-edge collision.
        always_ff @(posedge clk) begin
            if (i_a_en) begin
                r_a_q <= r_mem[i_a_addr];
            end
            if (i_b_en) begin
                r_b_q <= r_mem[i_b_addr];
            end
            if (i_w_be[k]) begin
                r_mem[i_w_addr] <= i_w_data[8*k +: 8];
            end
        end

        assign o_a_rdata[8*k +: 8] = r_a_q;
        assign o_b_rdata[8*k +: 8] = r_b_q;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_responder
//  Brief    : Unified fetch/load/store memory target with one-cycle registered
//             reads, range faults and saturating access counters.
//  Revision : 1.0
// ============================================================================
module cpu_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          ADDR_W      = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        instr_fault,
    output logic        data_fault,
    output logic [31:0] cnt_ifetch,
    output logic [31:0] cnt_dread,
    output logic [31:0] cnt_dwrite
);

    logic              w_i_ok;
    logic              w_d_ok;
    logic [ADDR_W-1:0] w_i_idx;
    logic [ADDR_W-1:0] w_d_idx;
    logic              w_i_acc;
    logic              w_d_rd_acc;
    logic [LANES-1:0]  w_d_we;
    logic              w_d_wr_acc;
    logic [WORD_W-1:0] w_i_rdata;
    logic [WORD_W-1:0] w_d_rdata;

    logic              r_i_zero;
    logic              r_d_zero;
    logic              r_instr_fault;
    logic              r_data_fault;
    logic [31:0]       r_cnt_ifetch;
    logic [31:0]       r_cnt_dread;
    logic [31:0]       r_cnt_dwrite;

    assign w_i_ok     = in_range(instr_addr, BASE_ADDR, DEPTH_WORDS);
    assign w_d_ok     = in_range(data_addr, BASE_ADDR, DEPTH_WORDS);
    assign w_i_idx    = ADDR_W'((instr_addr - BASE_ADDR) >> 2);
    assign w_d_idx    = ADDR_W'((data_addr - BASE_ADDR) >> 2);

    // Accesses presented on a reset edge are dropped, never partially applied.
    assign w_i_acc    = rst & instr_read & w_i_ok;
    assign w_d_rd_acc = rst & data_read & w_d_ok;
    assign w_d_we     = (rst & w_d_ok) ? data_write : '0;
    assign w_d_wr_acc = |w_d_we;

    mem_word_array #(
        .DEPTH  (int'(DEPTH_WORDS)),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .i_a_en    (w_i_acc),
        .i_a_addr  (w_i_idx),
        .o_a_rdata (w_i_rdata),
        .i_b_en    (w_d_rd_acc),
        .i_b_addr  (w_d_idx),
        .o_b_rdata (w_d_rdata),
        .i_w_be    (w_d_we),
        .i_w_addr  (w_d_idx),
        .i_w_data  (data_in)
    );

    // The array read registers carry no reset; a zero flag per port forces
    // the visible output to 0 after reset or an out-of-range read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_zero      <= 1'b1;
            r_d_zero      <= 1'b1;
            r_instr_fault <= 1'b0;
            r_data_fault  <= 1'b0;
            r_cnt_ifetch  <= '0;
            r_cnt_dread   <= '0;
            r_cnt_dwrite  <= '0;
        end else begin
            r_instr_fault <= instr_read & ~w_i_ok;
            r_data_fault  <= (data_read | (|data_write)) & ~w_d_ok;
            if (instr_read) begin
                r_i_zero <= ~w_i_ok;
            end
            if (data_read) begin
                r_d_zero <= ~w_d_ok;
            end
            if (w_i_acc) begin
                r_cnt_ifetch <= sat_inc(r_cnt_ifetch);
            end
            if (w_d_rd_acc) begin
                r_cnt_dread <= sat_inc(r_cnt_dread);
            end
            if (w_d_wr_acc) begin
                r_cnt_dwrite <= sat_inc(r_cnt_dwrite);
            end
        end
    end

    assign instr_out   = r_i_zero ? '0 : w_i_rdata;
    assign data_out    = r_d_zero ? '0 : w_d_rdata;
    assign instr_fault = r_instr_fault;
    assign data_fault  = r_data_fault;
    assign cnt_ifetch  = r_cnt_ifetch;
    assign cnt_dread   = r_cnt_dread;
    assign cnt_dwrite  = r_cnt_dwrite;

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Unified memory target that answers the CPU's instruction fetch port and data load/store port.
- Registered reads with one-cycle latency, which matches the CPU's fetch → decode and load → writeback stage spacing.
- Byte-lane writes, range checking with fault pulses, and saturating access counters for the testbench and performance reporting.
- Sits between the CPU and the testbench top, in place of separate behavioural instruction and data memories.

Parameters:
- DEPTH_WORDS, 16384: number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- ADDR_W, 14: index width, equal to clog2(DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- instr_read  in  1  fetch request, sampled each edge.
- instr_addr  in  32  fetch byte address.
- instr_out  out  32  fetched word.
- data_read  in  1  load request.
- data_write  in  4  byte-lane write enables; bit k covers data_in[8k+7:8k].
- data_addr  in  32  load/store byte address.
- data_in  in  32  store data, already lane-replicated by the CPU.
- data_out  out  32  loaded word.
- instr_fault  out  1  one-cycle pulse: fetch address out of range.
- data_fault  out  1  one-cycle pulse: load or store address out of range.
- cnt_ifetch  out  32  accepted fetch count.
- cnt_dread  out  32  accepted load count.
- cnt_dwrite  out  32  accepted store count.

Behaviour:
- Address decode
  - idx = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored for indexing.
  - An address is in range iff addr >= BASE_ADDR and idx < DEPTH_WORDS.
- Reset, sampled at an edge with rst = 0:
  - instr_out, data_out, instr_fault, data_fault and all counters go to 0.
  - Any pending read is discarded.
  - The memory array is NOT cleared; contents survive reset, including a reset asserted mid-run.
- Fetch
  - instr_read = 1 at edge N: instr_out = mem[idx] after edge N+1 (registered, latency 1).
  - Out of range: instr_out = 0, instr_fault = 1 for exactly one cycle, cnt_ifetch is not incremented.
  - instr_read = 0: instr_out holds its last value.
- Load
  - data_read = 1 at edge N: data_out = full word mem[idx] after edge N+1.
  - Lane selection and sign extension are done by the CPU.
  - Out of range: data_out = 0 and a data_fault pulse.
  - data_read = 0: data_out holds its last value.
- Store
  - data_write != 0 at edge N: for each set bit k, byte k of mem[idx] takes data_in byte k at edge N.
  - Any mask value is legal, including 4'b1111, 4'b0011, 4'b1100 and single bits.
  - Out of range: the write is dropped, data_fault pulses, cnt_dwrite is not incremented.
- Ordering and collisions
  - Same-edge read and write to the same word, on either port: the read returns the pre-write contents (read-first).
  - data_read and data_write both active: the write is performed and the load returns the old word. Both counters increment.
  - Fetch and load may hit the same word simultaneously; both return the same data.
  - Fetch fault and data fault may pulse in the same cycle.
- Counters
  - Each accepted access increments its counter by 1.
  - Counters saturate at 32'hFFFF_FFFF and do not wrap.
- No stall signalling: every request completes with fixed latency 1.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_W = 32 and LANES = 4;
  - the default BASE_ADDR and DEPTH_WORDS;
  - an in_range helper function.
- One natural sub-module, mem_word_array:
  - storage as 4 byte-wide lanes;
  - two synchronous read ports and one byte-masked write port, read-first.
- The top level contains address decode, fault pulses and counters.

Test Plan:
- Fetch latency and hold: preload mem[3] = 32'h00A00093; instr_read = 1, instr_addr = 12 at edge N → instr_out = 32'h00A00093 after N+1. Drop instr_read → value holds and cnt_ifetch = 1.
- Byte and half stores:
  - Start with mem[5] = 32'h11223344.
  - Write data_write = 4'b0100, data_addr = 22, data_in = 32'hABABABAB.
  - Load address 20 → data_out = 32'h11AB3344.
  - Write 4'b0011 with data_in = 32'hBEEFBEEF.
  - Load again → data_out = 32'h11ABBEEF.
- Read-first collision: mem[8] = 32'h0. Same edge: data_write = 4'b1111, data_addr = 32, data_in = 32'hCAFEF00D, instr_read with instr_addr = 32 → instr_out = 0. A fetch on the next edge → 32'hCAFEF00D.
- Out of range (DEPTH_WORDS = 16):
  - Load address 64 → data_out = 0, data_fault high for one cycle, cnt_dread unchanged.
  - Store to address 64 → no array change, data_fault pulse.
- Reset mid-run: after several accesses, hold rst = 0 for one edge → all outputs and counters read 0. Then fetch address 12 → still 32'h00A00093, confirming contents were preserved.
- Counter saturation: force cnt_dwrite = 32'hFFFF_FFFE, issue 3 in-range stores → cnt_dwrite = 32'hFFFF_FFFF.
